dmem_responder: RTL

- Memory-side responder for the core's data-memory port. Serves one load or store at a time over a valid/ready request channel and a valid/ready response channel.
- Has a programmable wait-state latency.
- Handles byte, halfword and word lanes, little-endian, with sign or zero extension on loads.
- Sits between the core's load/store path and a word-organised RAM array held inside the block; replaces the zero-latency data memory once the core gains a stall path.

---
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// dmem_if: request/response channel between the core's load/store path and
// the data-memory responder. The master is the core; the slave is the memory.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with programmable
// wait states, byte/halfword/word lanes (little-endian) and load extension.
// Optional macro DMEM_RESP_ERR_EN enables access-fault detection; without it
// accesses are forced aligned, size 11 acts as word and addresses wrap.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; operands come straight from the bus
// S_WAIT | wait states, counter runs 1..LATENCY on held operands
// S_RESP | response presented, held stable until rsp_ready
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus,
  output logic  busy
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;

  logic [31:0] r_addr;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_wdata;

  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic          w_accept;
  logic          w_enter_resp;
  logic [31:0]   w_addr;
  logic          w_we;
  logic [1:0]    w_size;
  logic          w_uns;
  logic [31:0]   w_wdata;
  logic [1:0]    w_size_eff;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_bshift;
  logic [31:0]   w_hshift;
  logic [31:0]   w_load;
  logic [31:0]   w_wmask;
  logic [31:0]   w_wlane;
  logic [31:0]   w_merged;

  assign w_accept     = (r_state == S_IDLE) && bus.req_valid;
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

  // In IDLE the zero-latency path must use the request as it arrives;
  // otherwise the held copy is the operand.
  assign w_addr  = (r_state == S_IDLE) ? bus.req_addr     : r_addr;
  assign w_we    = (r_state == S_IDLE) ? bus.req_we       : r_we;
  assign w_size  = (r_state == S_IDLE) ? bus.req_size     : r_size;
  assign w_uns   = (r_state == S_IDLE) ? bus.req_unsigned : r_uns;
  assign w_wdata = (r_state == S_IDLE) ? bus.req_wdata    : r_wdata;

  assign w_idx  = w_addr[AW+1:2];
  assign w_word = r_mem[w_idx];

`ifdef DMEM_RESP_ERR_EN
  // Fault on misalignment, reserved size, or an address past the array.
  always_comb begin
    w_size_eff = w_size;
    w_err      = 1'b0;
    if ((w_size == 2'b01) && w_addr[0])             w_err = 1'b1;
    if ((w_size == 2'b10) && (w_addr[1:0] != 2'b00)) w_err = 1'b1;
    if (w_size == 2'b11)                            w_err = 1'b1;
    if (|w_addr[31:AW+2])                           w_err = 1'b1;
  end
`else
  logic w_unused_addr;
  assign w_unused_addr = |w_addr[31:AW+2];

  // No faults: reserved size behaves as a word, upper address bits wrap.
  always_comb begin
    w_size_eff = (w_size == 2'b11) ? 2'b10 : w_size;
    w_err      = 1'b0;
  end
`endif

  // Lane extraction and extension for loads; halfword lane uses addr[1] only.
  always_comb begin
    w_bshift = w_word >> {w_addr[1:0], 3'b000};
    w_hshift = w_word >> {w_addr[1], 4'b0000};
    case (w_size_eff)
      2'b00:   w_load = w_uns ? {24'd0, w_bshift[7:0]}
                              : {{24{w_bshift[7]}}, w_bshift[7:0]};
      2'b01:   w_load = w_uns ? {16'd0, w_hshift[15:0]}
                              : {{16{w_hshift[15]}}, w_hshift[15:0]};
      default: w_load = w_word;
    endcase
  end

  // Store lane mask and replicated data; unselected bytes are merged back.
  always_comb begin
    case (w_size_eff)
      2'b00: begin
        w_wmask = 32'h0000_00FF << {w_addr[1:0], 3'b000};
        w_wlane = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask = w_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        w_wlane = {2{w_wdata[15:0]}};
      end
      default: begin
        w_wmask = 32'hFFFF_FFFF;
        w_wlane = w_wdata;
      end
    endcase
    w_merged = (w_word & ~w_wmask) | (w_wlane & w_wmask);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.req_valid) w_next = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == LAT) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Wait-state counter: first WAIT cycle sees 1, leaves WAIT at LATENCY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= (LATENCY == 0) ? 4'd0 : 4'd1;
    end else if (w_enter_resp) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Request holding registers, loaded at the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= 32'd0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_addr  <= bus.req_addr;
      r_we    <= bus.req_we;
      r_size  <= bus.req_size;
      r_uns   <= bus.req_unsigned;
      r_wdata <= bus.req_wdata;
    end
  end

  // Array write, only on the edge entering RESP; held off while in reset.
  always_ff @(posedge clk) begin
    if (reset && w_enter_resp && w_we && !w_err) r_mem[w_idx] <= w_merged;
  end

  // Response registers: loaded entering RESP, cleared on the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (w_we || w_err) ? 32'd0 : w_load;
      r_err   <= w_err;
    end else if ((r_state == S_RESP) && bus.rsp_ready) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign busy          = (r_state != S_IDLE);

endmodule
